// File: rtl/filter_iir1_multichannel.sv
// First-order IIR filter (B0 + B1 z^-1)/(1 + A1 z^-1), time-multiplexed over CHANNELS states, 3-cycle pipeline.
// Define FILTER_IIR1_SATURATE_EN to clamp internal/output narrowing instead of two's-complement wrap.
module filter_iir1_multichannel #(
    parameter int WIDTH    = 9,
    parameter int GUARD    = 2,
    parameter int CHANNELS = 1,
    parameter int B0       = 0,
    parameter int B1       = 0,
    parameter int A1       = 0,
    parameter int A_PREC   = 8,
    parameter int B_PREC   = 8,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_in_valid,
    input  logic signed [WIDTH-1:0] i_in,
    input  logic [CW-1:0]           i_in_ch,
    output logic                    o_out_valid,
    output logic signed [WIDTH-1:0] o_out,
    output logic [CW-1:0]           o_out_ch
);

    localparam int IW             = WIDTH + GUARD;
    localparam int DEPTH          = 1 << CW;
    localparam logic [CW:0] CH_LIM = CHANNELS[CW:0];

`ifdef FILTER_IIR1_SATURATE_EN
    localparam logic signed [31:0] IW_MAX = (32'sd1 <<< (IW - 1)) - 32'sd1;
    localparam logic signed [31:0] IW_MIN = -(32'sd1 <<< (IW - 1));
    localparam logic signed [31:0] W_MAX  = (32'sd1 <<< (WIDTH - 1)) - 32'sd1;
    localparam logic signed [31:0] W_MIN  = -(32'sd1 <<< (WIDTH - 1));
`endif

    // Round half toward +inf, then arithmetic shift.
    function automatic logic signed [31:0] rnd(input logic signed [31:0] p, input int s);
        return (p + (32'sd1 <<< (s - 1))) >>> s;
    endfunction

    function automatic logic signed [IW-1:0] fit_iw(input logic signed [31:0] a);
`ifdef FILTER_IIR1_SATURATE_EN
        if (a > IW_MAX) return IW'(IW_MAX);
        if (a < IW_MIN) return IW'(IW_MIN);
`endif
        return IW'(a);
    endfunction

    function automatic logic signed [WIDTH-1:0] fit_w(input logic signed [31:0] a);
`ifdef FILTER_IIR1_SATURATE_EN
        if (a > W_MAX) return WIDTH'(W_MAX);
        if (a < W_MIN) return WIDTH'(W_MIN);
`endif
        return WIDTH'(a);
    endfunction

    logic                    r_val0, r_val1, r_val2;
    logic signed [WIDTH-1:0] r_x0;
    logic [CW-1:0]           r_ch0, r_ch1, r_ch2;
    logic signed [IW-1:0]    r_state [DEPTH];
    logic signed [IW-1:0]    r_vp    [DEPTH];
    logic signed [IW-1:0]    r_v1, r_vp1;
    logic signed [31:0]      r_pb0, r_pb1;

    logic signed [IW-1:0]    w_v;
    logic signed [IW-1:0]    w_fb;

    assign w_v  = fit_iw(32'(r_x0) + 32'(r_state[r_ch0]));
    assign w_fb = fit_iw(rnd(-A1 * 32'(w_v), A_PREC));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_val0      <= 1'b0;
            r_val1      <= 1'b0;
            r_val2      <= 1'b0;
            r_x0        <= '0;
            r_ch0       <= '0;
            r_ch1       <= '0;
            r_ch2       <= '0;
            r_v1        <= '0;
            r_vp1       <= '0;
            r_pb0       <= '0;
            r_pb1       <= '0;
            o_out_valid <= 1'b0;
            o_out       <= '0;
            o_out_ch    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= '0;
                r_vp[i]    <= '0;
            end
        end else begin
            // S0: out-of-range channels are dropped here and never touch state.
            r_val0 <= i_in_valid && ({1'b0, i_in_ch} < CH_LIM);
            r_x0   <= i_in;
            r_ch0  <= i_in_ch;

            // S1: recursion; state is written back the same cycle so back-to-back samples see it.
            r_val1 <= r_val0;
            r_ch1  <= r_ch0;
            if (r_val0) begin
                r_state[r_ch0] <= w_fb;
                r_vp[r_ch0]    <= w_v;
                r_v1           <= w_v;
                r_vp1          <= r_vp[r_ch0];
            end

            r_val2 <= r_val1;
            r_ch2  <= r_ch1;
            if (r_val1) begin
                r_pb0 <= rnd(B0 * 32'(r_v1), B_PREC);
                r_pb1 <= rnd(B1 * 32'(r_vp1), B_PREC);
            end

            o_out_valid <= r_val2;
            if (r_val2) begin
                o_out    <= fit_w(r_pb0 + r_pb1);
                o_out_ch <= r_ch2;
            end
        end
    end

endmodule

// File: tb/tb_filter_iir1_multichannel.sv
// Bench for filter_iir1_multichannel: direct-arithmetic reference model plus literal expectations.
// Two instances: a 3-channel lowpass (A) and a 1-channel high-gain filter for overflow (B).
module tb_filter_iir1_multichannel;

    localparam int IW = 11;
    localparam int W  = 9;
`ifdef FILTER_IIR1_SATURATE_EN
    localparam int OVF_EXP = 255;
`else
    localparam int OVF_EXP = -112;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              iv_a, ov_a, iv_b, ov_b;
    logic signed [8:0] ix_a, oo_a, ix_b, oo_b;
    logic [1:0]        ich_a, och_a;
    logic [0:0]        ich_b, och_b;

    filter_iir1_multichannel #(.WIDTH(9), .GUARD(2), .CHANNELS(3), .B0(64), .B1(64), .A1(-128),
                               .A_PREC(8), .B_PREC(8)) u_dut_a (
        .i_clk(clk), .i_reset(rst), .i_in_valid(iv_a), .i_in(ix_a), .i_in_ch(ich_a),
        .o_out_valid(ov_a), .o_out(oo_a), .o_out_ch(och_a));

    filter_iir1_multichannel #(.WIDTH(9), .GUARD(2), .CHANNELS(1), .B0(128), .B1(128), .A1(-128),
                               .A_PREC(8), .B_PREC(8)) u_dut_b (
        .i_clk(clk), .i_reset(rst), .i_in_valid(iv_b), .i_in(ix_b), .i_in_ch(ich_b),
        .o_out_valid(ov_b), .o_out(oo_b), .o_out_ch(och_b));

    typedef struct {
        int dut;
        int due;
        int ch;
        int y;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   edge_n = 0;
    exp_t q[$];
    int   ka1[2] = '{-128, -128};
    int   kb0[2] = '{64, 128};
    int   kb1[2] = '{64, 128};
    int   nch[2] = '{3, 1};
    int   mr[2][4];
    int   mvp[2][4];
    int   last_out[2];
    int   vcount[2];
    int   seen0_y[$];
    int   seen0_ch[$];
    int   seen1_y[$];

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, expv, edge_n);
        end
    endtask

    function automatic int fit(input int a, input int w);
        int lim;
        int t;
        lim = 1 << (w - 1);
`ifdef FILTER_IIR1_SATURATE_EN
        if (a > lim - 1) return lim - 1;
        if (a < -lim) return -lim;
        return a;
`else
        t = a & ((1 << w) - 1);
        if (t >= lim) t = t - (1 << w);
        return t;
`endif
    endfunction

    function automatic int rnd(input int p, input int s);
        return (p + (1 << (s - 1))) >>> s;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int d = 0; d < 2; d++) begin
            last_out[d] = 0;
            for (int c = 0; c < 4; c++) begin
                mr[d][c]  = 0;
                mvp[d][c] = 0;
            end
        end
    endtask

    task automatic model_accept(input int d, input int ch, input int x);
        int   v;
        exp_t e;
        v     = fit(x + mr[d][ch], IW);
        e.dut = d;
        e.due = edge_n + 4;
        e.ch  = ch;
        e.y   = fit(rnd(kb0[d] * v, 8) + rnd(kb1[d] * mvp[d][ch], 8), W);
        mr[d][ch]  = fit(rnd(-ka1[d] * v, 8), IW);
        mvp[d][ch] = v;
        q.push_back(e);
    endtask

    // One input cycle: inputs change at the falling edge, the DUT samples at the next rising edge.
    task automatic drive(input bit rst_i, input int d, input bit v, input int ch, input int x);
        @(negedge clk);
        rst   = rst_i;
        iv_a  = 1'b0;
        iv_b  = 1'b0;
        if (d == 0) begin
            iv_a  = v;
            ix_a  = 9'(x);
            ich_a = 2'(ch);
        end else begin
            iv_b  = v;
            ix_b  = 9'(x);
            ich_b = 1'(ch);
        end
        if (rst_i) model_reset();
        else if (v && ch < nch[d]) model_accept(d, ch, x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic check_dut(input int d);
        int   idx;
        bit   expv;
        logic act_v;
        logic signed [8:0] act_o;
        logic [1:0] act_c;
        idx = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].dut == d) begin
                idx = i;
                break;
            end
        end
        expv  = (idx >= 0) && (q[idx].due == edge_n);
        act_v = (d == 0) ? ov_a : ov_b;
        act_o = (d == 0) ? oo_a : oo_b;
        act_c = (d == 0) ? och_a : {1'b0, och_b};
        chk(d == 0 ? "valid_a" : "valid_b", act_v, expv);
        if (act_v === 1'b1) vcount[d]++;
        if (expv) begin
            chk(d == 0 ? "out_a" : "out_b", act_o, q[idx].y);
            chk(d == 0 ? "ch_a" : "ch_b", act_c, q[idx].ch);
            last_out[d] = q[idx].y;
            if (d == 0) begin
                seen0_y.push_back(int'(act_o));
                seen0_ch.push_back(int'(act_c));
            end else begin
                seen1_y.push_back(int'(act_o));
            end
            q.delete(idx);
        end else begin
            chk(d == 0 ? "hold_a" : "hold_b", act_o, last_out[d]);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            check_dut(0);
            check_dut(1);
        end
    end

    function automatic int at0(input int i);
        if (i < seen0_y.size()) return seen0_y[i];
        return -9999;
    endfunction

    function automatic int ch0(input int i);
        if (i < seen0_ch.size()) return seen0_ch[i];
        return -9999;
    endfunction

    initial begin
        int acc;
        int vc0;
        int n1;
        bit mono;
        bit vv;
        int cc;
        rst = 1'b1;
        iv_a = 1'b0; ix_a = '0; ich_a = '0;
        iv_b = 1'b0; ix_b = '0; ich_b = '0;
        vcount[0] = 0;
        vcount[1] = 0;
        model_reset();

        // Reset held with a valid sample present, then quiet.
        repeat (3) drive(1'b1, 0, 1'b1, 0, 100);
        idle(3);

        // DC step on channel 0.
        seen0_y.delete(); seen0_ch.delete();
        repeat (30) drive(1'b0, 0, 1'b1, 0, 100);
        idle(4);
        chk("step_first", at0(0), 25);
        chk("step_second", at0(1), 63);
        chk("step_steady", at0(29), 100);
        mono = 1'b1;
        for (int i = 1; i < seen0_y.size(); i++) if (seen0_y[i] < seen0_y[i-1]) mono = 1'b0;
        chk("step_monotonic", 32'(mono), 1);

        // Interleave ch0/ch1, pause ch1 while ch0 runs, then resume ch1.
        drive(1'b1, 0, 1'b0, 0, 0);
        seen0_y.delete(); seen0_ch.delete();
        for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b1, i % 2, (i % 2) ? -100 : 100);
        repeat (10) drive(1'b0, 0, 1'b1, 0, 100);
        drive(1'b0, 0, 1'b1, 1, -100);
        idle(4);
        chk("il_ch0_first", at0(0), 25);
        chk("il_ch1_first", at0(1), -25);
        chk("il_ch0_second", at0(2), 63);
        chk("il_ch1_second", at0(3), -62);
        chk("il_ch1_tag", ch0(3), 1);
        chk("il_ch1_resume", at0(14), -81);
        chk("il_ch1_resume_tag", ch0(14), 1);

        // Overflow on the high-gain instance, with out-of-range channel 1 mixed in.
        drive(1'b1, 1, 1'b0, 0, 0);
        seen1_y.delete();
        for (int i = 0; i < 40; i++) drive(1'b0, 1, 1'b1, (i % 7 == 3) ? 1 : 0, 200);
        idle(4);
        n1 = seen1_y.size();
        chk("ovf_count", n1, 40 - 6);
        chk("ovf_steady", (n1 > 0) ? seen1_y[n1-1] : -9999, OVF_EXP);

        // Random gaps and invalid channel 3 on the 3-channel instance.
        drive(1'b1, 0, 1'b0, 0, 0);
        acc = 0;
        vc0 = vcount[0];
        for (int i = 0; i < 80; i++) begin
            vv = 1'($urandom_range(0, 1));
            cc = int'($urandom_range(0, 3));
            drive(1'b0, 0, vv, cc, int'($urandom_range(0, 400)) - 200);
            if (vv && cc < 3) acc++;
        end
        idle(4);
        chk("gap_valid_count", vcount[0] - vc0, acc);

        // Reset in the middle of a ramp kills in-flight samples.
        drive(1'b1, 0, 1'b0, 0, 0);
        repeat (6) drive(1'b0, 0, 1'b1, 0, 100);
        drive(1'b1, 0, 1'b1, 0, 100);
        seen0_y.delete(); seen0_ch.delete();
        repeat (8) drive(1'b0, 0, 1'b1, 0, 100);
        idle(4);
        chk("mrst_first", at0(0), 25);
        chk("mrst_second", at0(1), 63);
        chk("mrst_count", seen0_y.size(), 8);

        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/filter_iir1_multichannel.md
# filter_iir1_multichannel

Parametrised first-order IIR filter, H(z) = (B0 + B1·z⁻¹) / (1 + A1·z⁻¹), with fixed-point coefficients. It serves CHANNELS independent, time-multiplexed sample streams, each with its own state, and has a valid handshake and a fixed 3-cycle pipeline. It is the general successor to the per-standard fixed chroma/luma lowpass filters in the video filter chain. The SECAM, PAL and NTSC paths instantiate it with coefficients from `coefficients.svh`.

## Interface
- WIDTH, 9: sample width, signed two's complement, for in and out.
- GUARD, 2: extra integer bits on the internal recursion value v and feedback r. Internal width IW = WIDTH+GUARD.
- CHANNELS, 1: number of independent filter states, ≥1.
- B0, B1, A1, 0: signed integer coefficients, scaled by 2^B_PREC and 2^A_PREC. A1 uses the standard denominator sign; no inversion is done by the caller.
- A_PREC, B_PREC, 8: fractional bits, each ≥1.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in/in_ch are sampled this cycle.
- in  in  WIDTH  signed input sample.
- in_ch  in  CW  channel index, CW = max(1, $clog2(CHANNELS)).
- out_valid  out  1  out/out_ch are valid this cycle.
- out  out  WIDTH  signed filtered sample.
- out_ch  out  CW  channel of out.

## Operation
- rnd(p, s) = (p + 2^(s-1)) >>> s: arithmetic shift, so halves round toward +∞.
- Per channel c, state is r[c] (IW bits) and vp[c] (previous v, IW bits). For an accepted sample x:
  - v = fit(x + r[c])
  - r[c] ← fit(rnd(−A1·v, A_PREC))
  - y = fitW(rnd(B0·v, B_PREC) + rnd(B1·vp[c], B_PREC))
  - vp[c] ← v
- Products and sums are computed at 32-bit width before fitting.
- A sample is accepted when in_valid=1 and in_ch < CHANNELS.
  - If in_ch ≥ CHANNELS the sample is dropped: no state change, no output.
- Channel states are fully independent. A channel's state changes only when one of its own samples is accepted.
- There is no backpressure. The filter accepts one sample every cycle, and back-to-back samples on the same channel are legal; r and vp update in the same cycle v is formed.
- fit/fitW narrow to IW or WIDTH bits according to the Configuration macro.
- Reset clears r[*], vp[*], all pipeline valids and registers, out, out_ch and out_valid to 0.

## Timing
Pipeline stages, for a sample accepted at edge t:
- **S0**, edge t: register x, ch, valid.
- **S1**, edge t+1: form v, update r/vp, register v_q and vp_q.
- **S2**, edge t+2: register both rounded B products.
- **S3**, edge t+3: register the fitted sum to out; out_valid=1 for exactly one cycle.

Rules:
- Latency is exactly 3 cycles from the sampling edge to out_valid high.
- Output order equals input order.
- out holds its last value while out_valid=0.
- Reset asserted mid-stream kills all in-flight samples. out_valid=0 from the first edge with reset=1. The first sample accepted after reset sees zero state.
- Simultaneous reset and in_valid: reset wins and the sample is discarded.

## Configuration
`FILTER_IIR1_SATURATE_EN`
- **Defined:** fit clamps to [−2^(IW−1), 2^(IW−1)−1] and fitW clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- **Undefined:** fit and fitW truncate to the low IW / WIDTH bits (two's-complement wrap). This is the legacy behaviour, and it saves the clamp logic.

## Test plan
All scenarios use A_PREC=B_PREC=8 and WIDTH=9 unless stated.

1. **Reset.** Hold reset 3 cycles, in_valid=1, in=100 → out_valid=0 and out=0 throughout; out_valid stays 0 for 3 cycles after release with in_valid=0.
2. **DC step, unity-gain lowpass.** CHANNELS=1, A1=−128, B0=B1=64, constant in=100 from t0 → out_valid first at t0+3. Outputs are 25, 63, then monotonically rising to a steady 100.
3. **Interleave.** CHANNELS=2, same coefficients. Alternate ch0=100 and ch1=−100 every cycle → out_ch alternates. ch0 outputs 25, 63, …; ch1 outputs −25, −62, …. Then ch1 pauses 10 cycles while ch0 continues, and ch1 resumes at its next value, −?, derived from the untouched state.
4. **Overflow.** B0=B1=128, A1=−128, in=200 constant → steady y=400 → out=255 with the macro defined; out=−112 without it.
5. **Gaps and invalid channel.** CHANNELS=3; in_valid toggled 1/0 randomly, and samples with in_ch=3 injected → outputs match a golden model that ignores gaps and drops ch3. out_valid count equals the number of accepted samples.
6. **Mid-stream reset.** Assert reset for 1 cycle during scenario 2's ramp → no out_valid from in-flight samples. The next step reproduces the 25, 63 sequence exactly.
